// File: rtl/and_equiv_checker.sv
// and_equiv_checker: on-chip response checker for the N-input AND family.
// It sweeps every stimulus vector in ascending order and holds each one long
// enough for the implementations to settle. It then compares every
// implementation output against the golden reduction AND. The checker records
// how many vectors failed, which implementations failed, and the first
// failing vector.
module and_equiv_checker #(
    parameter int N_INPUTS      = 2,
    parameter int N_IMPL        = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [N_INPUTS-1:0] stim,
    input  logic [N_IMPL-1:0]   dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic [N_IMPL-1:0]   fail_mask,
    output logic                fail_valid,
    output logic [N_INPUTS-1:0] first_fail_vec
);

    localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 exp_bit;
    logic [N_IMPL-1:0]    mism;
    logic                 any_mism;
    logic [N_INPUTS:0]    err_next;

    // Golden value for the vector on the stim lines and the per-impl mismatch.
    // err_next is the error count that includes the vector being checked.
    always_comb begin
        exp_bit  = &stim;
        mism     = dut_out ^ {N_IMPL{exp_bit}};
        any_mism = |mism;
        err_next = err_count + {{N_INPUTS{1'b0}}, any_mism};
    end

    // Sweep controller. All results are registered. A restart from DONE
    // clears them the same way a start from IDLE does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_mask      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        stim           <= '0;
                        cnt            <= SETTLE_INIT;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        fail_mask      <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_vec <= '0;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (any_mism) begin
                        err_count <= err_next;
                        fail_mask <= fail_mask | mism;
                        if (!fail_valid) begin
                            first_fail_vec <= stim;
                            fail_valid     <= 1'b1;
                        end
                    end
                    if (&stim) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= DONE;
                    end else begin
                        stim  <= stim + 1'b1;
                        cnt   <= SETTLE_INIT;
                        state <= SETTLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_equiv_checker.sv
// Directed bench for and_equiv_checker. Instance A uses N=2, S=2 with
// selectable faulty implementations. Instance B uses N=3, S=1 with correct
// implementations.
module tb_and_equiv_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic startA = 1'b0;
    logic startB = 1'b0;
    int   faultMode = 0;

    logic [1:0] stimA;
    logic [2:0] dutA;
    logic       busyA, doneA, passA, fvA;
    logic [2:0] errA;
    logic [2:0] maskA;
    logic [1:0] ffvA;

    logic [2:0] stimB;
    logic [2:0] dutB;
    logic       busyB, doneB, passB, fvB;
    logic [3:0] errB;
    logic [2:0] maskB;
    logic [2:0] ffvB;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Implementation models for instance A.
    // Mode 1: impl 1 is stuck at 0. Mode 2: impl 2 is stuck at 1.
    always_comb begin
        dutA = {3{&stimA}};
        if (faultMode == 1) dutA[1] = 1'b0;
        if (faultMode == 2) dutA[2] = 1'b1;
        dutB = {3{&stimB}};
    end

    and_equiv_checker #(.N_INPUTS(2), .N_IMPL(3), .SETTLE_CYCLES(2)) dutInstA (
        .clk(clk), .rst(rst), .start(startA), .stim(stimA), .dut_out(dutA),
        .busy(busyA), .done(doneA), .pass(passA), .err_count(errA),
        .fail_mask(maskA), .fail_valid(fvA), .first_fail_vec(ffvA)
    );

    and_equiv_checker #(.N_INPUTS(3), .N_IMPL(3), .SETTLE_CYCLES(1)) dutInstB (
        .clk(clk), .rst(rst), .start(startB), .stim(stimB), .dut_out(dutB),
        .busy(busyB), .done(doneB), .pass(passB), .err_count(errB),
        .fail_mask(maskB), .fail_valid(fvB), .first_fail_vec(ffvB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResults(input int which, input string tag, input logic expPass,
                                input logic [31:0] expErr, input logic [31:0] expMask,
                                input logic expFv, input logic [31:0] expFfv);
        if (which == 0) begin
            checkOutput({tag, " done"}, 32'(doneA), 32'd1);
            checkOutput({tag, " pass"}, 32'(passA), 32'(expPass));
            checkOutput({tag, " err_count"}, 32'(errA), expErr);
            checkOutput({tag, " fail_mask"}, 32'(maskA), expMask);
            checkOutput({tag, " fail_valid"}, 32'(fvA), 32'(expFv));
            checkOutput({tag, " first_fail_vec"}, 32'(ffvA), expFfv);
        end else begin
            checkOutput({tag, " done"}, 32'(doneB), 32'd1);
            checkOutput({tag, " pass"}, 32'(passB), 32'(expPass));
            checkOutput({tag, " err_count"}, 32'(errB), expErr);
            checkOutput({tag, " fail_mask"}, 32'(maskB), expMask);
            checkOutput({tag, " fail_valid"}, 32'(fvB), 32'(expFv));
            checkOutput({tag, " first_fail_vec"}, 32'(ffvB), expFfv);
        end
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, " A stim"}, 32'(stimA), 32'd0);
        checkOutput({tag, " A busy"}, 32'(busyA), 32'd0);
        checkOutput({tag, " A done"}, 32'(doneA), 32'd0);
        checkOutput({tag, " A pass"}, 32'(passA), 32'd0);
        checkOutput({tag, " A err_count"}, 32'(errA), 32'd0);
        checkOutput({tag, " A fail_mask"}, 32'(maskA), 32'd0);
        checkOutput({tag, " A fail_valid"}, 32'(fvA), 32'd0);
        checkOutput({tag, " A first_fail_vec"}, 32'(ffvA), 32'd0);
        checkOutput({tag, " B busy"}, 32'(busyB), 32'd0);
        checkOutput({tag, " B done"}, 32'(doneB), 32'd0);
        checkOutput({tag, " B err_count"}, 32'(errB), 32'd0);
    endtask

    // Pulse start for one instance and follow the sweep cycle by cycle.
    // Stim is checked against the expected sweep order and the cycle count
    // at which done rises is checked. When extraStartAt > 0, start is
    // re-asserted for one cycle during the sweep.
    task automatic applyStimulus(input int which, input int extraStartAt, input string tag);
        int cycles;
        int vecCycles;
        int maxStim;
        int expStim;
        logic [31:0] obsStim, obsBusy, obsDone, obsErr, obsMask, obsFv;
        vecCycles = (which == 0) ? 3 : 2;
        maxStim   = (which == 0) ? 3 : 7;
        @(negedge clk);
        if (which == 0) startA = 1'b1; else startB = 1'b1;
        @(posedge clk);
        #1;
        startA = 1'b0;
        startB = 1'b0;
        obsBusy = (which == 0) ? 32'(busyA) : 32'(busyB);
        obsDone = (which == 0) ? 32'(doneA) : 32'(doneB);
        obsErr  = (which == 0) ? 32'(errA)  : 32'(errB);
        obsMask = (which == 0) ? 32'(maskA) : 32'(maskB);
        obsFv   = (which == 0) ? 32'(fvA)   : 32'(fvB);
        checkOutput({tag, " busy after start"}, obsBusy, 32'd1);
        checkOutput({tag, " done after start"}, obsDone, 32'd0);
        checkOutput({tag, " err cleared"}, obsErr, 32'd0);
        checkOutput({tag, " mask cleared"}, obsMask, 32'd0);
        checkOutput({tag, " fail_valid cleared"}, obsFv, 32'd0);
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clk);
            cycles++;
            #1;
            obsStim = (which == 0) ? 32'(stimA) : 32'(stimB);
            obsDone = (which == 0) ? 32'(doneA) : 32'(doneB);
            expStim = cycles / vecCycles;
            if (expStim > maxStim) expStim = maxStim;
            checkOutput($sformatf("%s stim@%0d", tag, cycles), obsStim, 32'(expStim));
            if (obsDone == 32'd1) break;
            if (cycles == extraStartAt) begin
                if (which == 0) startA = 1'b1; else startB = 1'b1;
            end else begin
                startA = 1'b0;
                startB = 1'b0;
            end
        end
        startA = 1'b0;
        startB = 1'b0;
        obsBusy = (which == 0) ? 32'(busyA) : 32'(busyB);
        checkOutput({tag, " done cycle"}, 32'(cycles), 32'((maxStim + 1) * vecCycles));
        checkOutput({tag, " busy at done"}, obsBusy, 32'd0);
    endtask

    initial begin
        // Reset both instances.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkCleared("reset");
        rst = 1'b0;

        // All implementations correct.
        faultMode = 0;
        applyStimulus(0, 0, "T1");
        checkResults(0, "T1", 1'b1, 0, 3'b000, 1'b0, 0);

        // Impl 1 stuck at 0: only vector 3 fails.
        faultMode = 1;
        applyStimulus(0, 0, "T2");
        checkResults(0, "T2", 1'b0, 1, 3'b010, 1'b1, 2'b11);

        // Impl 2 stuck at 1: vectors 0, 1 and 2 fail.
        faultMode = 2;
        applyStimulus(0, 0, "T3");
        checkResults(0, "T3", 1'b0, 3, 3'b100, 1'b1, 2'b00);

        // Reset five cycles into a sweep, then run a clean sweep.
        faultMode = 0;
        @(negedge clk);
        startA = 1'b1;
        @(posedge clk);
        #1;
        startA = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkCleared("T4 abort");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("T4 stays idle busy", 32'(busyA), 32'd0);
        applyStimulus(0, 0, "T4");
        checkResults(0, "T4", 1'b1, 0, 3'b000, 1'b0, 0);

        // Start while busy is ignored, then a restart from DONE clears results.
        faultMode = 1;
        applyStimulus(0, 4, "T5a");
        checkResults(0, "T5a", 1'b0, 1, 3'b010, 1'b1, 2'b11);
        faultMode = 0;
        applyStimulus(0, 0, "T5b");
        checkResults(0, "T5b", 1'b1, 0, 3'b000, 1'b0, 0);

        // Three-input instance with single-cycle settle.
        applyStimulus(1, 0, "T6");
        checkResults(1, "T6", 1'b1, 0, 3'b000, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
